// File: rtl/ft232h_pkt_gen.sv
// Framed test-packet source for the ft232h FIFO bridge: writes A5 5A N <payload> <checksum>
// one byte per Avalon write to the bridge TX register, throttled only by waitrequest.
module ft232h_pkt_gen #(
  parameter logic [7:0] TX_ADDR    = 8'h01,
  parameter int         GAP_CYCLES = 4,
  parameter logic [7:0] HDR0       = 8'hA5,
  parameter logic [7:0] HDR1       = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  pkt_len,
  output logic [7:0]  avalon_address,
  output logic        avalon_read,
  output logic        avalon_write,
  output logic [31:0] avalon_writedata,
  input  logic [31:0] avalon_readdata,
  input  logic        avalon_waitrequest,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [7:0]  seq,
  output logic [2:0]  state_dbg
);

  // Handshake: a byte transfers on a rising clk with avalon_write=1 and avalon_waitrequest=0;
  // while stalled, avalon_write and avalon_writedata hold and the FSM does not advance.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEAD0   = 3'd1,
    HEAD1   = 3'd2,
    LEN     = 3'd3,
    PAYLOAD = 3'd4,
    CSUM    = 3'd5,
    GAP     = 3'd6
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  state_t     state;
  logic [7:0] tx_byte;
  logic [7:0] len_q;
  logic [7:0] remaining;
  logic [7:0] checksum;
  logic [7:0] gap_cnt;
  logic       accept;
  logic [7:0] csum_next;
  logic       unused_readdata;

  assign accept           = avalon_write && !avalon_waitrequest;
  assign csum_next        = checksum + tx_byte;
  assign avalon_address   = TX_ADDR;
  assign avalon_read      = 1'b0;
  assign avalon_writedata = {24'b0, tx_byte};
  assign state_dbg        = state;
  assign unused_readdata  = ^avalon_readdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      avalon_write <= 1'b0;
      tx_byte      <= 8'd0;
      busy         <= 1'b0;
      pkt_count    <= 16'd0;
      seq          <= 8'd0;
      checksum     <= 8'd0;
      gap_cnt      <= 8'd0;
      len_q        <= 8'd0;
      remaining    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            len_q        <= pkt_len;
            checksum     <= 8'd0;
            avalon_write <= 1'b1;
            tx_byte      <= HDR0;
            busy         <= 1'b1;
            state        <= HEAD0;
          end
        end
        HEAD0: begin
          if (accept) begin
            tx_byte <= HDR1;
            state   <= HEAD1;
          end
        end
        HEAD1: begin
          if (accept) begin
            tx_byte <= len_q;
            state   <= LEN;
          end
        end
        LEN: begin
          if (accept) begin
            checksum <= len_q;
            if (len_q == 8'd0) begin
              // Empty payload: checksum equals N, which is zero.
              tx_byte <= len_q;
              state   <= CSUM;
            end else begin
              tx_byte   <= seq;
              remaining <= len_q;
              state     <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (accept) begin
            checksum  <= csum_next;
            seq       <= seq + 8'd1;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) begin
              tx_byte <= csum_next;
              state   <= CSUM;
            end else begin
              tx_byte <= seq + 8'd1;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            pkt_count    <= pkt_count + 16'd1;
            avalon_write <= 1'b0;
            busy         <= 1'b0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= 8'd1) state <= IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft232h_pkt_gen.sv
// Directed bench for ft232h_pkt_gen: expected frame bytes are queued as stimulus is issued and
// a negedge monitor pops and compares every accepted Avalon write.
module tb_ft232h_pkt_gen;

  localparam int GAP = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  pkt_len;
  logic [7:0]  avalon_address;
  logic        avalon_read;
  logic        avalon_write;
  logic [31:0] avalon_writedata;
  logic [31:0] avalon_readdata;
  logic        avalon_waitrequest;
  logic        busy;
  logic [15:0] pkt_count;
  logic [7:0]  seq;
  logic [2:0]  state_dbg;

  logic [7:0]  exp_q[$];
  int          total;
  int          bad;
  logic [15:0] exp_pkts;

  ft232h_pkt_gen #(.GAP_CYCLES(GAP)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .pkt_len            (pkt_len),
    .avalon_address     (avalon_address),
    .avalon_read        (avalon_read),
    .avalon_write       (avalon_write),
    .avalon_writedata   (avalon_writedata),
    .avalon_readdata    (avalon_readdata),
    .avalon_waitrequest (avalon_waitrequest),
    .busy               (busy),
    .pkt_count          (pkt_count),
    .seq                (seq),
    .state_dbg          (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && avalon_write && !avalon_waitrequest) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", avalon_writedata, 32'hFFFF_FFFF);
      end else begin
        check("tx_byte", avalon_writedata, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic push_pkt(input logic [7:0] len, input logic [7:0] start, input logic [7:0] csum);
    logic [7:0] b;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(len);
    b = start;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(b);
      b = b + 8'd1;
    end
    exp_q.push_back(csum);
  endtask

  task automatic wait_pkts(input logic [15:0] target);
    int n;
    n = 0;
    while (pkt_count !== target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("pkt_timeout", {16'b0, pkt_count}, {16'b0, target});
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("busy_timeout", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_present(input logic [7:0] val, output bit found);
    found = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(posedge clk);
      #1;
      if (state_dbg == 3'd4 && avalon_writedata == {24'b0, val}) found = 1;
    end
    if (!found) check("present_timeout", avalon_writedata, {24'b0, val});
  endtask

  task automatic run_one(input logic [7:0] len);
    pkt_len = len;
    enable  = 1'b1;
    wait_busy();
    enable   = 1'b0;
    exp_pkts = exp_pkts + 16'd1;
    wait_pkts(exp_pkts);
    repeat (GAP + 2) @(negedge clk);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_state", {29'b0, state_dbg}, 32'd0);
  endtask

  task automatic do_reset();
    enable             = 1'b0;
    avalon_waitrequest = 1'b0;
    #3 rst_n = 1'b0;
    exp_q.delete();
    exp_pkts = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic stall_second_byte();
    bit found;
    wait_present(8'h01, found);
    if (found) begin
      avalon_waitrequest = 1'b1;
      pkt_len = 8'd9;
      repeat (3) begin
        @(negedge clk);
        check("stall_write", {31'b0, avalon_write}, 32'd1);
        check("stall_data", avalon_writedata, 32'h0000_0001);
        @(posedge clk);
      end
      #1 avalon_waitrequest = 1'b0;
    end
  endtask

  initial begin
    int  gap_n;
    bit  found;
    total = 0;
    bad = 0;
    exp_pkts = 16'd0;
    rst_n = 1'b0;
    enable = 1'b0;
    pkt_len = 8'd0;
    avalon_readdata = 32'hDEAD_BEEF;
    avalon_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write", {31'b0, avalon_write}, 32'd0);
    check("rst_data", avalon_writedata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pkts", {16'b0, pkt_count}, 32'd0);
    check("rst_seq", {24'b0, seq}, 32'd0);
    check("rst_state", {29'b0, state_dbg}, 32'd0);
    check("addr", {24'b0, avalon_address}, 32'h01);
    check("read", {31'b0, avalon_read}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("disabled_write", {31'b0, avalon_write}, 32'd0);

    // N=4 then a second back-to-back packet, measuring the inter-packet gap
    push_pkt(8'd4, 8'h00, 8'h0A);
    pkt_len = 8'd4;
    enable = 1'b1;
    wait_pkts(16'd1);
    check("pkt1_count", {16'b0, pkt_count}, 32'd1);
    check("pkt1_busy_low", {31'b0, busy}, 32'd0);
    push_pkt(8'd4, 8'h04, 8'h1A);
    gap_n = 0;
    while (!avalon_write && gap_n < 50) begin
      @(negedge clk);
      gap_n++;
    end
    enable = 1'b0;
    check("gap_cycles", gap_n, GAP + 1);
    wait_pkts(16'd2);
    repeat (GAP + 2) @(negedge clk);
    check("pkt2_seq", {24'b0, seq}, 32'h08);
    check("pkt2_queue", exp_q.size(), 0);

    // async reset in the middle of a payload
    push_pkt(8'd8, 8'h08, 8'h64);
    pkt_len = 8'd8;
    enable = 1'b1;
    wait_present(8'h0A, found);
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_write", {31'b0, avalon_write}, 32'd0);
    check("abort_pkts", {16'b0, pkt_count}, 32'd0);
    check("abort_seq", {24'b0, seq}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    exp_q.delete();
    exp_pkts = 16'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_abort_write", {31'b0, avalon_write}, 32'd0);

    // stall on the second payload byte; mid-packet pkt_len change is ignored
    push_pkt(8'd4, 8'h00, 8'h0A);
    fork
      run_one(8'd4);
      stall_second_byte();
    join
    check("stall_queue", exp_q.size(), 0);

    // empty payload
    push_pkt(8'd0, 8'h04, 8'h00);
    run_one(8'd0);
    check("len0_seq", {24'b0, seq}, 32'h04);
    check("len0_pkts", {16'b0, pkt_count}, 32'd2);

    // two maximum-length packets straddling the seq wrap
    do_reset();
    push_pkt(8'd1, 8'h00, 8'h01);
    run_one(8'd1);
    check("wrap_seq_start", {24'b0, seq}, 32'h01);
    push_pkt(8'd255, 8'h01, 8'h7F);
    push_pkt(8'd255, 8'h00, 8'h80);
    pkt_len = 8'd255;
    enable = 1'b1;
    wait_pkts(exp_pkts + 16'd1);
    wait_busy();
    enable = 1'b0;
    exp_pkts = exp_pkts + 16'd2;
    wait_pkts(exp_pkts);
    repeat (GAP + 2) @(negedge clk);
    check("wrap_seq_end", {24'b0, seq}, 32'hFF);
    check("wrap_queue", exp_q.size(), 0);

    // enable dropped during the second payload byte of an N=8 packet
    push_pkt(8'd8, 8'hFF, 8'h1C);
    pkt_len = 8'd8;
    enable = 1'b1;
    wait_present(8'h00, found);
    enable = 1'b0;
    pkt_len = 8'd3;
    exp_pkts = exp_pkts + 16'd1;
    wait_pkts(exp_pkts);
    repeat (GAP + 4) @(negedge clk);
    check("drop_pkts", {16'b0, pkt_count}, {16'b0, exp_pkts});
    check("drop_busy", {31'b0, busy}, 32'd0);
    check("drop_state", {29'b0, state_dbg}, 32'd0);
    check("drop_write", {31'b0, avalon_write}, 32'd0);
    check("drop_queue", exp_q.size(), 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
